arb_mux_rr: RTL

//  Registered N-channel arbitrating multiplexer: the sequential successor to the fixed-select muxN family.
//  NCH valid/ready input channels compete for one output register; winner chosen round-robin or fixed-priority.

---
 rtl/arb_mux_rr.sv | 63 ++++++
 1 files changed

// File: rtl/arb_mux_rr.sv
// arb_mux_rr: registered N-channel valid/ready arbitrating mux, round-robin or fixed priority
module arb_mux_rr #(
  parameter int WIDTH = 32,
  parameter int NCH = 4,
  parameter int PRIO_MODE = 0,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic [NCH-1:0]     in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]     in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  input  logic               out_ready
);
  logic [SELW-1:0] ptr_q, ptr_d, win, sel, ch_q, ch_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, found, load, take;
  int idx;
  // Scan from ptr upward with wrap; in fixed mode ptr stays 0 so this is lowest-index-wins.
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = 0;
    sel = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(ptr_q) + k) % NCH;
      sel = SELW'(idx);
      if (!found && in_valid[sel]) begin
        found = 1'b1;
        win = sel;
      end
    end
  end
  assign load = ~valid_q | out_ready;
  assign take = found & load & ~flush & reset_n;
  assign in_ready = take ? (NCH'(1) << win) : '0;
  always_comb begin
    valid_d = flush ? 1'b0 : load ? take : valid_q;
    data_d = take ? in_data[win*WIDTH +: WIDTH] : data_q;
    ch_d = take ? win : ch_q;
    ptr_d = flush ? '0 : (take && PRIO_MODE == 0) ? ((int'(win) == NCH-1) ? '0 : win + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q <= '0;
      ch_q <= '0;
      ptr_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      ch_q <= ch_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign out_ch = ch_q;
endmodule
